// File: rtl/ramp_waveform_generator.sv
// Multi-mode ramp source: triangle, saw-up, saw-down and single-shot triangle sweeps
// between run-time limits, with dwell at each extreme and a clamped phase accumulator.
module ramp_waveform_generator #(
  parameter int OUT_WIDTH   = 14,
  parameter int FRAC_BITS   = 20,
  parameter int STEP_WIDTH  = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic                          trigger,
  input  logic signed [STEP_WIDTH-1:0]  step_size,
  input  logic signed [OUT_WIDTH-1:0]   max_out,
  input  logic signed [OUT_WIDTH-1:0]   min_out,
  input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
  output logic signed [OUT_WIDTH-1:0]   out,
  output logic                          sync,
  output logic                          busy,
  output logic                          period_done
);

  localparam int ACC_W = OUT_WIDTH + FRAC_BITS + 1;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    DWELL_TOP,
    FALL,
    DWELL_BOT
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]               mode_q, mode_d;
  logic [DWELL_WIDTH-1:0]   dwellCnt_q, dwellCnt_d;
  logic                     periodDone_q, periodDone_d;

  logic signed [ACC_W-1:0]  lMax, lMin, stepExt, headroom, floorroom;
  logic                     stepOk, limitsOk;
  logic signed [OUT_WIDTH:0] limSum, midPoint, outExt;

  assign lMax      = {max_out[OUT_WIDTH-1], max_out, {FRAC_BITS{1'b0}}};
  assign lMin      = {min_out[OUT_WIDTH-1], min_out, {FRAC_BITS{1'b0}}};
  assign stepExt   = {{(ACC_W-STEP_WIDTH){step_size[STEP_WIDTH-1]}}, step_size};
  assign headroom  = lMax - acc_q;
  assign floorroom = acc_q - lMin;
  // A non-positive step stalls the ramp rather than running it backwards.
  assign stepOk    = !stepExt[ACC_W-1] && (stepExt != '0);
  assign limitsOk  = max_out > min_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= lMin;
      mode_q       <= 2'd0;
      dwellCnt_q   <= '0;
      periodDone_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      dwellCnt_q   <= dwellCnt_d;
      periodDone_q <= periodDone_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    dwellCnt_d   = dwellCnt_q;
    periodDone_d = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          mode_d = mode;
          if (limitsOk) begin
            case (mode)
              2'd0, 2'd1: begin
                acc_d   = lMin;
                state_d = RISE;
              end
              2'd2: begin
                acc_d   = lMax;
                state_d = FALL;
              end
              default: begin
                if (trigger) begin
                  acc_d   = lMin;
                  state_d = RISE;
                end
              end
            endcase
          end
        end
        RISE: begin
          if (limitsOk && stepOk) begin
            // Negative headroom (limit lowered mid-sweep) also lands here and clamps.
            if (headroom <= stepExt) begin
              acc_d      = lMax;
              dwellCnt_d = dwell_cycles;
              state_d    = DWELL_TOP;
            end else begin
              acc_d = acc_q + stepExt;
            end
          end
        end
        FALL: begin
          if (limitsOk && stepOk) begin
            if (floorroom <= stepExt) begin
              acc_d      = lMin;
              dwellCnt_d = dwell_cycles;
              state_d    = DWELL_BOT;
            end else begin
              acc_d = acc_q - stepExt;
            end
          end
        end
        DWELL_TOP: begin
          if (dwellCnt_q != '0) begin
            dwellCnt_d = dwellCnt_q - 1'b1;
          end else if (mode_q == 2'd1) begin
            acc_d        = lMin;
            periodDone_d = 1'b1;
            state_d      = RISE;
          end else begin
            state_d = FALL;
          end
        end
        DWELL_BOT: begin
          if (dwellCnt_q != '0) begin
            dwellCnt_d = dwellCnt_q - 1'b1;
          end else begin
            periodDone_d = 1'b1;
            case (mode_q)
              2'd2: begin
                acc_d   = lMax;
                state_d = FALL;
              end
              2'd3:    state_d = IDLE;
              default: state_d = RISE;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out         = acc_q[FRAC_BITS +: OUT_WIDTH];
    limSum      = $signed({max_out[OUT_WIDTH-1], max_out}) + $signed({min_out[OUT_WIDTH-1], min_out});
    midPoint    = limSum >>> 1;
    outExt      = $signed({out[OUT_WIDTH-1], out});
    sync        = outExt > midPoint;
    busy        = state_q != IDLE;
    period_done = periodDone_q;
  end

endmodule

// File: tb/tb_ramp_waveform_generator.sv
// Directed bench for ramp_waveform_generator: each step drives inputs, clocks once and
// compares outputs against hand-computed sequences.
module tb_ramp_waveform_generator;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [1:0]         mode;
  logic               trigger;
  logic signed [31:0] step_size;
  logic signed [13:0] max_out;
  logic signed [13:0] min_out;
  logic [15:0]        dwell_cycles;
  logic signed [13:0] out;
  logic               sync;
  logic               busy;
  logic               period_done;

  int checks = 0;
  int errors = 0;

  ramp_waveform_generator dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .mode         (mode),
    .trigger      (trigger),
    .step_size    (step_size),
    .max_out      (max_out),
    .min_out      (min_out),
    .dwell_cycles (dwell_cycles),
    .out          (out),
    .sync         (sync),
    .busy         (busy),
    .period_done  (period_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] md,
                               input logic trig, input int stepLsb, input int minV,
                               input int maxV, input int dwell);
    reset        = rst;
    enable       = en;
    mode         = md;
    trigger      = trig;
    step_size    = stepLsb * 32'sd1048576;
    min_out      = 14'(minV);
    max_out      = 14'(maxV);
    dwell_cycles = 16'(dwell);
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  int t1Out[12] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1};
  int t2Out[10] = '{-3, -2, -1, 0, 1, 2, 2, 2, -3, -2};
  int t3Out[9]  = '{1, 2, 3, 3, 2, 1, 0, 0, 0};
  int t4Out[12] = '{0, 3, 6, 9, 10, 10, 7, 4, 1, 0, 0, 3};
  int t5Dwell[4] = '{10, 10, 10, 9};

  initial begin
    logic pdSeen;
    logic busySeen;
    logic outMoved;

    // T1: triangle 0..4, no dwell, then reset state checks
    applyStimulus(1, 1, 2'd0, 0, 1, 0, 4, 0);
    tick();
    tick();
    checkOutput("rst_out", out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pd", period_done, 0);
    checkOutput("rst_sync", sync, 0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput($sformatf("t1_out%0d", i), out, t1Out[i]);
      checkOutput($sformatf("t1_pd%0d", i), period_done, (i == 10) ? 1 : 0);
      checkOutput($sformatf("t1_busy%0d", i), busy, 1);
      checkOutput($sformatf("t1_sync%0d", i), sync, (t1Out[i] > 2) ? 1 : 0);
    end

    // T2: saw-up -3..2 with dwell 2, sync high when out >= 0
    applyStimulus(1, 1, 2'd1, 0, 1, -3, 2, 2);
    tick();
    checkOutput("t2_rst_out", out, -3);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("t2_out%0d", i), out, t2Out[i]);
      checkOutput($sformatf("t2_pd%0d", i), period_done, (i == 8) ? 1 : 0);
      checkOutput($sformatf("t2_sync%0d", i), sync, (t2Out[i] >= 0) ? 1 : 0);
    end

    // T3: single-shot waits for trigger, sweeps once, returns to idle
    applyStimulus(1, 1, 2'd3, 0, 1, 0, 3, 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("t3_wait_out", out, 0);
    checkOutput("t3_wait_busy", busy, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checkOutput("t3_start_out", out, 0);
    checkOutput("t3_start_busy", busy, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      checkOutput($sformatf("t3_out%0d", i), out, t3Out[i]);
      checkOutput($sformatf("t3_pd%0d", i), period_done, (i == 7) ? 1 : 0);
      checkOutput($sformatf("t3_busy%0d", i), busy, (i >= 7) ? 0 : 1);
    end

    // T4: step of 3 LSB clamps exactly onto both limits
    applyStimulus(1, 1, 2'd0, 0, 3, 0, 10, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput($sformatf("t4_out%0d", i), out, t4Out[i]);
      checkOutput($sformatf("t4_pd%0d", i), period_done, (i == 10) ? 1 : 0);
    end

    // T5: freeze during ramp and during dwell, then reset mid-fall
    applyStimulus(1, 1, 2'd0, 0, 1, 0, 10, 3);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("t5_pre_out", out, 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("t5_frz_out%0d", i), out, 3);
      checkOutput($sformatf("t5_frz_busy%0d", i), busy, 1);
    end
    enable = 1'b1;
    tick();
    checkOutput("t5_resume0", out, 4);
    tick();
    checkOutput("t5_resume1", out, 5);
    repeat (5) tick();
    checkOutput("t5_top", out, 10);
    tick();
    checkOutput("t5_dwell", out, 10);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t5_dfrz%0d", i), out, 10);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t5_dres%0d", i), out, t5Dwell[i]);
    end
    tick();
    checkOutput("t5_fall", out, 8);
    reset = 1'b1;
    tick();
    checkOutput("t5_rst_out", out, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_pd", period_done, 0);
    reset = 1'b0;

    // T7: lowering max mid-rise clamps the accumulator onto the new limit
    applyStimulus(1, 1, 2'd0, 0, 1, 0, 10, 0);
    tick();
    reset = 1'b0;
    repeat (7) tick();
    checkOutput("t7_pre", out, 6);
    max_out = 14'sd4;
    tick();
    checkOutput("t7_clamp", out, 4);
    tick();
    checkOutput("t7_dwell", out, 4);
    tick();
    checkOutput("t7_fall", out, 3);

    // T6a: equal limits never start a sweep
    applyStimulus(1, 1, 2'd0, 0, 1, 5, 5, 0);
    tick();
    reset = 1'b0;
    pdSeen   = 1'b0;
    busySeen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      pdSeen   = pdSeen | period_done;
      busySeen = busySeen | busy;
    end
    checkOutput("t6a_busy", busySeen, 0);
    checkOutput("t6a_pd", pdSeen, 0);
    checkOutput("t6a_out", out, 5);

    // T6b: zero step stalls in the ramp state
    applyStimulus(1, 1, 2'd0, 0, 0, 0, 4, 0);
    tick();
    reset = 1'b0;
    pdSeen   = 1'b0;
    outMoved = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      pdSeen   = pdSeen | period_done;
      outMoved = outMoved | (out != 14'sd0);
    end
    checkOutput("t6b_pd", pdSeen, 0);
    checkOutput("t6b_moved", outMoved, 0);
    checkOutput("t6b_busy", busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
